// File: rtl/pipe_exc_if.sv
// Bundle between the ID-stage decode and the exception sequencer: ID-stage
// status and decode flags flow in, PC redirect / cancel / ack strobes and the
// EPC, Cause and IE state flow out. No handshake; every signal is a per-cycle level.
// Ports: intr, d_valid, d_stall, d_isbd, d_syscall, d_eret, dpc (to sequencer);
//        cancel, redirect, exc_pc, inta, epc, cause, ie (from sequencer).
interface pipe_exc_if;
   logic        intr;
   logic        d_valid;
   logic        d_stall;
   logic        d_isbd;
   logic        d_syscall;
   logic        d_eret;
   logic [31:0] dpc;
   logic        cancel;
   logic        redirect;
   logic [31:0] exc_pc;
   logic        inta;
   logic [31:0] epc;
   logic [31:0] cause;
   logic        ie;

   // Pipeline side: drives the ID-stage view, consumes the strobes.
   modport master (
      output intr, d_valid, d_stall, d_isbd, d_syscall, d_eret, dpc,
      input  cancel, redirect, exc_pc, inta, epc, cause, ie
   );

   // Sequencer side.
   modport slave (
      input  intr, d_valid, d_stall, d_isbd, d_syscall, d_eret, dpc,
      output cancel, redirect, exc_pc, inta, epc, cause, ie
   );
endinterface

// File: rtl/pipe_exc_ctl.sv
// Interrupt / syscall / eret sequencer for the ID stage; owns EPC, Cause, IE.
// Latency: redirect/cancel/inta combinational in the take/return cycle; state at next posedge.
// Backpressure: d_stall (or d_valid=0) holds the sequencer; a pending interrupt waits past delay slots.
// Ports: clk, clrn (async active-low reset), bus (pipe_exc_if.slave).
module pipe_exc_ctl #(
   parameter logic [31:0] VECTOR   = 32'h0000_0008,
   parameter logic [4:0]  INT_CODE = 5'd0,
   parameter logic [4:0]  SYS_CODE = 5'd8,
   parameter logic        IE_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       clrn,
   pipe_exc_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  code_q, code_d;
   logic        ie_q, ie_d;

   logic        ok;
   logic        cancel_c;
   logic        redirect_c;
   logic        inta_c;
   logic [31:0] exc_pc_c;

   // The ID instruction may act only when it is real and not interlocked.
   assign ok = bus.d_valid & ~bus.d_stall;

   always_comb begin
      state_d    = state_q;
      epc_d      = epc_q;
      code_d     = code_q;
      ie_d       = ie_q;
      cancel_c   = 1'b0;
      redirect_c = 1'b0;
      inta_c     = 1'b0;
      exc_pc_c   = VECTOR;

      case (state_q)
         S_IDLE: begin
            if (ok && bus.d_syscall) begin
               redirect_c = 1'b1;
               cancel_c   = 1'b1;
               exc_pc_c   = VECTOR;
               epc_d      = bus.dpc;
               code_d     = SYS_CODE;
               ie_d       = 1'b0;
               state_d    = S_FLUSH;
            end else if (ok && bus.d_eret) begin
               // Return target is the EPC held before this edge.
               redirect_c = 1'b1;
               cancel_c   = 1'b1;
               exc_pc_c   = epc_q;
               ie_d       = 1'b1;
               state_d    = S_FLUSH;
            end else if (bus.intr && ie_q) begin
               // Request is latched here; it survives intr dropping.
               state_d = S_PEND;
            end
         end

         S_PEND: begin
            // Never interrupt a delay-slot instruction: EPC would lose the branch.
            if (ok && !bus.d_isbd) begin
               redirect_c = 1'b1;
               cancel_c   = 1'b1;
               inta_c     = 1'b1;
               exc_pc_c   = VECTOR;
               epc_d      = bus.dpc;
               code_d     = INT_CODE;
               ie_d       = 1'b0;
               state_d    = S_FLUSH;
            end
         end

         S_FLUSH: begin
            // Kill the wrong-path instruction fetched alongside the redirect.
            cancel_c = 1'b1;
            state_d  = (bus.intr && ie_q) ? S_PEND : S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         epc_q   <= 32'h0;
         code_q  <= 5'd0;
         ie_q    <= IE_RESET;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         code_q  <= code_d;
         ie_q    <= ie_d;
      end
   end

   assign bus.cancel   = cancel_c;
   assign bus.redirect = redirect_c;
   assign bus.inta     = inta_c;
   assign bus.exc_pc   = exc_pc_c;
   assign bus.epc      = epc_q;
   assign bus.cause    = {25'b0, code_q, 2'b00};
   assign bus.ie       = ie_q;

endmodule

// File: tb/tb_pipe_exc_ctl.sv
module tb_pipe_exc_ctl;

   logic clk;
   logic clrn;

   pipe_exc_if bus ();

   pipe_exc_ctl dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        intr, vld, stall, isbd, sys, eret;
      logic [31:0] dpc;
      logic        cancel, redirect, inta;
      logic [31:0] exc_pc;
      logic [31:0] epc, cause;
      logic        ie;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model: pending request, flush bubble and architectural registers.
   bit          m_pend, m_flush;
   logic [31:0] m_epc;
   logic [4:0]  m_code;
   logic        m_ie;
   bit          n_pend, n_flush;
   logic [31:0] n_epc;
   logic [4:0]  n_code;
   logic        n_ie;
   logic        e_cancel, e_redirect, e_inta;
   logic [31:0] e_pc;
   vec_t        cur;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_flush = 0; m_epc = 32'h0; m_code = 5'd0; m_ie = 1'b1;
   endtask

   // Decide what the sequencer must do this cycle from the current inputs.
   task automatic model_eval();
      bit ok;
      bit take_int, take_sys, do_ret;
      ok = cur.vld && !cur.stall;
      take_int = !m_flush && m_pend && ok && !cur.isbd;
      take_sys = !m_flush && !m_pend && ok && cur.sys;
      do_ret   = !m_flush && !m_pend && ok && !cur.sys && cur.eret;
      e_redirect = take_int || take_sys || do_ret;
      e_cancel   = e_redirect || m_flush;
      e_inta     = take_int;
      e_pc       = do_ret ? m_epc : 32'h8;
      n_epc  = (take_int || take_sys) ? cur.dpc : m_epc;
      n_code = take_int ? 5'd0 : (take_sys ? 5'd8 : m_code);
      n_ie   = (take_int || take_sys) ? 1'b0 : (do_ret ? 1'b1 : m_ie);
      n_flush = e_redirect;
      if (m_flush)         n_pend = cur.intr && m_ie;
      else if (m_pend)     n_pend = !take_int;
      else if (e_redirect) n_pend = 0;
      else                 n_pend = cur.intr && m_ie;
   endtask

   task automatic model_commit();
      m_pend = n_pend; m_flush = n_flush; m_epc = n_epc; m_code = n_code; m_ie = n_ie;
   endtask

   // One clock: drive at posedge+1, check combinational strobes, then registers after the edge.
   task automatic cycle(input bit use_tbl, input vec_t v);
      logic        x_cancel, x_redirect, x_inta, x_ie;
      logic [31:0] x_pc, x_epc, x_cause;
      cur = v;
      bus.intr = v.intr; bus.d_valid = v.vld; bus.d_stall = v.stall;
      bus.d_isbd = v.isbd; bus.d_syscall = v.sys; bus.d_eret = v.eret; bus.dpc = v.dpc;
      #1;
      model_eval();
      x_cancel   = use_tbl ? v.cancel   : e_cancel;
      x_redirect = use_tbl ? v.redirect : e_redirect;
      x_inta     = use_tbl ? v.inta     : e_inta;
      x_pc       = use_tbl ? v.exc_pc   : e_pc;
      chk("cancel",   {31'b0, bus.cancel},   {31'b0, x_cancel});
      chk("redirect", {31'b0, bus.redirect}, {31'b0, x_redirect});
      chk("inta",     {31'b0, bus.inta},     {31'b0, x_inta});
      if (x_redirect) chk("exc_pc", bus.exc_pc, x_pc);
      @(posedge clk);
      model_commit();
      #1;
      x_epc   = use_tbl ? v.epc   : m_epc;
      x_cause = use_tbl ? v.cause : {25'b0, m_code, 2'b00};
      x_ie    = use_tbl ? v.ie    : m_ie;
      chk("epc",   bus.epc,   x_epc);
      chk("cause", bus.cause, x_cause);
      chk("ie",    {31'b0, bus.ie}, {31'b0, x_ie});
   endtask

   function automatic vec_t mk(input logic intr, vld, stall, isbd, sys, eret,
                               input logic [31:0] dpc,
                               input logic cancel, redirect, inta,
                               input logic [31:0] exc_pc, epc, cause,
                               input logic ie);
      vec_t v;
      v.intr = intr; v.vld = vld; v.stall = stall; v.isbd = isbd; v.sys = sys; v.eret = eret;
      v.dpc = dpc; v.cancel = cancel; v.redirect = redirect; v.inta = inta;
      v.exc_pc = exc_pc; v.epc = epc; v.cause = cause; v.ie = ie;
      return v;
   endfunction

   function automatic vec_t in_only(input logic intr, vld, stall, isbd, sys, eret,
                                    input logic [31:0] dpc);
      return mk(intr, vld, stall, isbd, sys, eret, dpc, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   vec_t tbl [25];

   initial begin
      //            intr vld stl bd sys ert dpc      can red ack exc_pc   epc      cause ie
      tbl[0]  = mk(1, 1, 0, 0, 0, 0, 32'h40,  0, 0, 0, 32'h0,   32'h0,   32'h0,  1);
      tbl[1]  = mk(0, 1, 0, 0, 0, 0, 32'h40,  1, 1, 1, 32'h8,   32'h40,  32'h0,  0);
      tbl[2]  = mk(0, 1, 0, 0, 0, 0, 32'h44,  1, 0, 0, 32'h0,   32'h40,  32'h0,  0);
      tbl[3]  = mk(0, 1, 0, 0, 0, 0, 32'h8,   0, 0, 0, 32'h0,   32'h40,  32'h0,  0);
      tbl[4]  = mk(0, 1, 1, 0, 1, 0, 32'h100, 0, 0, 0, 32'h0,   32'h40,  32'h0,  0);
      tbl[5]  = mk(0, 1, 1, 0, 1, 0, 32'h100, 0, 0, 0, 32'h0,   32'h40,  32'h0,  0);
      tbl[6]  = mk(0, 1, 0, 0, 1, 0, 32'h100, 1, 1, 0, 32'h8,   32'h100, 32'h20, 0);
      tbl[7]  = mk(0, 1, 0, 0, 0, 0, 32'h104, 1, 0, 0, 32'h0,   32'h100, 32'h20, 0);
      tbl[8]  = mk(0, 1, 0, 0, 0, 0, 32'h8,   0, 0, 0, 32'h0,   32'h100, 32'h20, 0);
      tbl[9]  = mk(1, 1, 0, 0, 0, 1, 32'h20,  1, 1, 0, 32'h100, 32'h100, 32'h20, 1);
      tbl[10] = mk(1, 1, 0, 0, 0, 0, 32'h100, 1, 0, 0, 32'h0,   32'h100, 32'h20, 1);
      tbl[11] = mk(1, 1, 0, 0, 0, 0, 32'h100, 1, 1, 1, 32'h8,   32'h100, 32'h0,  0);
      tbl[12] = mk(1, 1, 0, 0, 0, 0, 32'h8,   1, 0, 0, 32'h0,   32'h100, 32'h0,  0);
      tbl[13] = mk(0, 1, 0, 0, 0, 1, 32'h30,  1, 1, 0, 32'h100, 32'h100, 32'h0,  1);
      tbl[14] = mk(0, 1, 0, 0, 0, 0, 32'h34,  1, 0, 0, 32'h0,   32'h100, 32'h0,  1);
      tbl[15] = mk(1, 1, 0, 1, 0, 0, 32'h50,  0, 0, 0, 32'h0,   32'h100, 32'h0,  1);
      tbl[16] = mk(0, 1, 0, 1, 0, 0, 32'h50,  0, 0, 0, 32'h0,   32'h100, 32'h0,  1);
      tbl[17] = mk(0, 1, 0, 1, 0, 0, 32'h50,  0, 0, 0, 32'h0,   32'h100, 32'h0,  1);
      tbl[18] = mk(0, 1, 0, 1, 0, 0, 32'h50,  0, 0, 0, 32'h0,   32'h100, 32'h0,  1);
      tbl[19] = mk(0, 1, 0, 0, 0, 0, 32'h54,  1, 1, 1, 32'h8,   32'h54,  32'h0,  0);
      tbl[20] = mk(0, 1, 0, 0, 0, 0, 32'h58,  1, 0, 0, 32'h0,   32'h54,  32'h0,  0);
      tbl[21] = mk(0, 1, 0, 0, 0, 1, 32'h60,  1, 1, 0, 32'h54,  32'h54,  32'h0,  1);
      tbl[22] = mk(1, 1, 0, 0, 0, 0, 32'h54,  1, 0, 0, 32'h0,   32'h54,  32'h0,  1);
      tbl[23] = mk(0, 1, 0, 0, 1, 0, 32'h70,  1, 1, 1, 32'h8,   32'h70,  32'h0,  0);
      tbl[24] = mk(0, 1, 0, 0, 1, 0, 32'h74,  1, 0, 0, 32'h0,   32'h70,  32'h0,  0);

      // Reset state, checked while reset is still asserted.
      clrn = 1'b0;
      bus.intr = 0; bus.d_valid = 0; bus.d_stall = 0; bus.d_isbd = 0;
      bus.d_syscall = 0; bus.d_eret = 0; bus.dpc = 32'h0;
      model_reset();
      #12;
      chk("rst_epc",      bus.epc,   32'h0);
      chk("rst_cause",    bus.cause, 32'h0);
      chk("rst_ie",       {31'b0, bus.ie},       32'h1);
      chk("rst_cancel",   {31'b0, bus.cancel},   32'h0);
      chk("rst_redirect", {31'b0, bus.redirect}, 32'h0);
      chk("rst_inta",     {31'b0, bus.inta},     32'h0);
      clrn = 1'b1;
      @(posedge clk);
      #1;

      // Directed table: interrupt, stalled syscall, eret with pending intr,
      // delay-slot deferral, interrupt beating a syscall in PEND, FLUSH ignoring syscall.
      for (int i = 0; i < 25; i++) cycle(1'b1, tbl[i]);

      // Masked interrupt: ie=0 here, intr held for 10 cycles.
      for (int i = 0; i < 10; i++) cycle(1'b0, in_only(1, 1, 0, 0, 0, 0, 32'h200 + 32'(i * 4)));
      chk("masked_ie", {31'b0, bus.ie}, 32'h0);

      // Reset in the middle of PEND.
      cycle(1'b0, in_only(0, 1, 0, 0, 0, 1, 32'h300));   // eret -> ie=1
      cycle(1'b0, in_only(1, 1, 0, 0, 0, 0, 32'h70));    // FLUSH -> PEND
      cycle(1'b0, in_only(0, 0, 0, 0, 0, 0, 32'h74));    // bubble, stays PEND
      bus.d_valid = 1; bus.dpc = 32'h80;
      #1;
      chk("pend_redirect", {31'b0, bus.redirect}, 32'h1);
      clrn = 1'b0;
      #1;
      chk("arst_redirect", {31'b0, bus.redirect}, 32'h0);
      chk("arst_cancel",   {31'b0, bus.cancel},   32'h0);
      chk("arst_inta",     {31'b0, bus.inta},     32'h0);
      chk("arst_epc",      bus.epc,   32'h0);
      chk("arst_cause",    bus.cause, 32'h0);
      chk("arst_ie",       {31'b0, bus.ie},       32'h1);
      model_reset();
      clrn = 1'b1;
      @(posedge clk);
      #1;
      // Latched request was lost: valid ID instruction passes untouched.
      cycle(1'b0, in_only(0, 1, 0, 0, 0, 0, 32'h84));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         vec_t v;
         v = in_only($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                     {$urandom_range(0, 32'h3fff_ffff), 2'b00});
         cycle(1'b0, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_exc_ctl.md
# pipe_exc_ctl

Interrupt/exception sequencer for the five-stage pipelined CPU. It watches the instruction in the ID stage and decides when an external interrupt, a syscall or an eret takes effect. It drives the PC redirect and the cancel strobe that turns the ID-stage instruction into a bubble before it enters the D/E pipeline register. It owns the EPC, Cause and interrupt-enable state.

## Interface
- VECTOR, 32'h0000_0008, exception handler entry address
- INT_CODE, 5'd0, Cause ExcCode for external interrupt
- SYS_CODE, 5'd8, Cause ExcCode for syscall
- IE_RESET, 1'b1, interrupt-enable value after reset
- clk  in  1  pipeline clock, all state updates on posedge
- clrn  in  1  asynchronous active-low reset, one clock, reset asynchronous active-low
- intr  in  1  external interrupt request, level
- d_valid  in  1  ID holds a real instruction (not a bubble)
- d_stall  in  1  ID is held this cycle (load-use interlock)
- d_isbd  in  1  ID instruction sits in a branch delay slot
- d_syscall  in  1  ID instruction decodes as syscall
- d_eret  in  1  ID instruction decodes as eret
- dpc  in  32  PC of ID instruction
- cancel  out  1  force dwreg/dwmem/djal to 0 into D/E register this cycle
- redirect  out  1  PC mux selects exc_pc this cycle
- exc_pc  out  32  VECTOR on take, epc on eret
- inta  out  1  one-cycle interrupt acknowledge
- epc  out  32  saved PC
- cause  out  32  {25'b0, ExcCode, 2'b00}
- ie  out  1  interrupt enable

## Operation
- States: IDLE, PEND, FLUSH; encoded 2 bits, registered.
- ok = d_valid & ~d_stall (ID instruction may act this cycle).
- IDLE:
  - ok & d_syscall: take syscall; epc<=dpc, cause code<=SYS_CODE, ie<=0; -> FLUSH.
  - else ok & d_eret: return; ie<=1; -> FLUSH.
  - Otherwise intr & ie: -> PEND. Latched: PEND persists even if intr drops.
  - A syscall/eret and intr in the same IDLE cycle: the syscall/eret acts; the interrupt is re-evaluated from FLUSH.
- PEND:
  - ok & ~d_isbd: take interrupt (wins over syscall/eret in ID); epc<=dpc, cause code<=INT_CODE, ie<=0, inta=1; -> FLUSH.
  - d_isbd or ~ok: stay PEND, no outputs asserted.
- FLUSH: cancel=1 (kills wrong-path instruction fetched during redirect); d_syscall/d_eret ignored; -> PEND if intr & ie, else IDLE.
- Any take or return asserts redirect=1, cancel=1 combinationally in that cycle; exc_pc = VECTOR on take, epc (pre-update value) on eret.
- In the take cycle the ID instruction is cancelled and re-executed after eret (EPC = its own PC).
- Syscall/eret in a delay slot is not supported; software guarantees it never happens. The block acts on them regardless of d_isbd.
- cancel/redirect/inta/exc_pc are combinational from state + ID inputs; epc/cause/ie/state are registered.

## Timing
- Reset (clrn=0, immediate, asynchronous): state=IDLE, epc=0, cause=0, ie=IE_RESET, cancel=0, redirect=0, inta=0.
- Reset mid-operation aborts PEND/FLUSH; the latched request is lost, and intr is re-sampled after release.
- Interrupt latency: intr high in cycle T (IDLE, ie=1) -> PEND at T+1 -> take no earlier than T+1 -> FLUSH next cycle -> handler instruction in ID two cycles after take.
- Syscall/eret: redirect in the cycle ok is true, cancel in that cycle and the next, so exactly 2 bubbles.
- The d_stall cycle delays take/return until the stall releases; the state holds.
- epc/cause/ie update at the posedge ending the take/return cycle.

## Test plan
- Reset: clrn=0 mid-PEND -> state IDLE, epc=0, cause=0, ie=1, all strobes 0 asynchronously.
- Interrupt: intr=1 one cycle, dpc=0x40, d_valid=1 -> PEND, next cycle redirect=1, exc_pc=0x8, inta=1, cancel=1. Then epc=0x40, cause=0x00, ie=0; FLUSH cancel=1 one cycle; IDLE.
- Delay slot: PEND with d_isbd=1 for 3 cycles then 0, dpc=0x54 -> no take during isbd; take on 4th cycle, epc=0x54.
- Syscall with stall: d_syscall=1, dpc=0x100, d_stall=1 two cycles -> nothing; then redirect=1, exc_pc=0x8, cause=0x20, epc=0x100, ie=0, 2 cancel cycles.
- Eret with pending intr: epc=0x40, ie=0, intr=1, d_eret -> exc_pc=0x40, ie=1; FLUSH -> PEND -> next eligible take, inta=1.
- Interrupt masked: ie=0, intr=1 for 10 cycles -> stays IDLE, no inta.
